// File: rtl/ysyx_25030081_wbu.sv
// Write-back unit: arbitrates EXU/LSU results onto a registered register-file
// write port and tracks outstanding loads in a busy scoreboard.
module ysyx_25030081_wbu #(
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          exu_valid,
  output logic                          exu_ready,
  input  logic                          exu_wen,
  input  logic [RF_ADDR_WIDTH-1:0]      exu_rd,
  input  logic [DATA_WIDTH-1:0]         exu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [RF_ADDR_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]         lsu_data,
  input  logic                          ld_issue,
  input  logic [RF_ADDR_WIDTH-1:0]      ld_rd,
  output logic                          rf_wen,
  output logic [RF_ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic [(1<<RF_ADDR_WIDTH)-1:0] busy_mask,
  output logic [31:0]                   wb_count,
  output logic                          err
);

  localparam int unsigned NREGS = 1 << RF_ADDR_WIDTH;

  logic                     rf_wen_q, rf_wen_d;
  logic [RF_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]    rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]         busy_q, busy_d;
  logic [31:0]              wb_count_q, wb_count_d;
  logic                     err_q, err_d;

  logic             lsu_xfer, exu_xfer;
  logic             lsu_err, ld_err;
  logic [NREGS-1:0] set_mask, clr_mask;

  // Handshake is combinational: LSU always wins, nothing accepted in reset.
  assign lsu_ready = rst_n;
  assign exu_ready = rst_n & ~lsu_valid;

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_count_d = wb_count_q;
    set_mask   = '0;
    clr_mask   = '0;
    lsu_err    = 1'b0;
    ld_err     = 1'b0;

    lsu_xfer = rst_n & lsu_valid;
    exu_xfer = rst_n & exu_valid & ~lsu_valid;

    if (lsu_xfer) begin
      if (lsu_rd != '0) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = lsu_rd;
        rf_wdata_d = lsu_data;
      end
    end else if (exu_xfer) begin
      if (exu_wen && (exu_rd != '0)) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = exu_rd;
        rf_wdata_d = exu_data;
      end
    end

    if (lsu_xfer || exu_xfer) begin
      wb_count_d = wb_count_q + 32'd1;
    end

    if (lsu_xfer) begin
      clr_mask = NREGS'(1) << lsu_rd;
    end
    if (rst_n && ld_issue && (ld_rd != '0)) begin
      set_mask = NREGS'(1) << ld_rd;
    end
    // Set is applied after clear so a re-issued load keeps its bit.
    busy_d = (busy_q & ~clr_mask) | set_mask;

    lsu_err = lsu_xfer && (lsu_rd != '0) && !busy_q[lsu_rd];
    ld_err  = rst_n && ld_issue && (ld_rd != '0) && busy_q[ld_rd] &&
              !(lsu_xfer && (lsu_rd == ld_rd));
    err_d   = err_q | lsu_err | ld_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      wb_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      wb_count_q <= wb_count_d;
      err_q      <= err_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_mask = busy_q;
  assign wb_count  = wb_count_q;
  assign err       = err_q;

endmodule
